cluster_task_sched: RTL and testbench

Slot-based task scheduler in front of the NHI-to-cluster demultiplexer. Each incoming task descriptor gets a free buffer slot in one cluster, chosen round-robin over clusters that have a free slot. The block emits the slot's absolute L1 address, which the NHI uses as the AXI write address, so the demux routes the payload to the chosen cluster. Slots return to the pool on completion notifications from the clusters.

---
 rtl/cluster_task_sched_pkg.sv | 46 ++++
 rtl/cluster_slot_alloc.sv | 62 ++++++
 rtl/cluster_task_sched.sv | 205 ++++++++++++++++++++
 tb/tb_cluster_task_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_task_sched_pkg.sv
// -----------------------------------------------------------------------------
// cluster_task_sched_pkg
// Shared types and helpers for the cluster task scheduler.
//   cl_idx_t / slot_idx_t / disp_t : index and dispatch-entry types for the
//                                    default configuration (4 clusters,
//                                    8 slots, 32-bit address, 8-bit id)
//   out_state_e                    : output register occupancy
//   idx_width()                    : index width for a count, minimum 1 bit
//   slot_addr()                    : base + slot * slot_bytes, 64-bit wide;
//                                    callers truncate to their address width
//                                    (AddrWidth must not exceed 64)
// -----------------------------------------------------------------------------
package cluster_task_sched_pkg;

  localparam int unsigned DefNumClusters     = 32'd4;
  localparam int unsigned DefSlotsPerCluster = 32'd8;
  localparam int unsigned DefAddrWidth       = 32'd32;
  localparam int unsigned DefTaskIdWidth     = 32'd8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

  typedef logic [idx_width(DefNumClusters)-1:0] cl_idx_t;
  typedef logic [$clog2(DefSlotsPerCluster)-1:0] slot_idx_t;

  typedef struct packed {
    cl_idx_t                   cluster;
    slot_idx_t                 slot;
    logic [DefAddrWidth-1:0]   addr;
    logic [DefTaskIdWidth-1:0] id;
  } disp_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Wraps modulo 2^64; the caller's truncation gives modulo 2^AddrWidth.
  function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                            input logic [31:0] slot,
                                            input logic [31:0] slot_bytes);
    return base + (64'(slot) * 64'(slot_bytes));
  endfunction

endpackage

// File: rtl/cluster_slot_alloc.sv
// -----------------------------------------------------------------------------
// cluster_slot_alloc
// Free-slot bitmap of one cluster (1 = free, all free after reset).
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   alloc_i          : take the slot shown on free_slot_o this cycle
//   release_i        : return release_slot_i to the pool
//   release_slot_i   : slot being released
//   any_free_o       : at least one slot free (registered bitmap, so a
//                      release becomes visible the cycle after it happens)
//   free_slot_o      : lowest-index free slot
//   err_o            : release of a slot that is already free (pulse)
// -----------------------------------------------------------------------------
module cluster_slot_alloc
  import cluster_task_sched_pkg::*;
#(
  parameter  int unsigned SlotsPerCluster = 32'd8,
  localparam int unsigned SlotW           = $clog2(SlotsPerCluster)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic             release_i,
  input  logic [SlotW-1:0] release_slot_i,
  output logic             any_free_o,
  output logic [SlotW-1:0] free_slot_o,
  output logic             err_o
);

  logic [SlotsPerCluster-1:0] r_free;
  logic [SlotsPerCluster-1:0] w_alloc_mask;
  logic [SlotsPerCluster-1:0] w_rel_mask;
  logic                       w_rel_legal;

  assign any_free_o = |r_free;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_slot_o = '0;
    for (int i = int'(SlotsPerCluster) - 1; i >= 0; i--) begin
      free_slot_o = r_free[i] ? SlotW'(i) : free_slot_o;
    end
  end

  // A release of an already-free slot (including the slot being allocated in
  // the same cycle, which is free beforehand) is ignored and reported.
  always_comb begin
    w_rel_legal  = release_i & ~r_free[release_slot_i];
    err_o        = release_i & r_free[release_slot_i];
    w_alloc_mask = alloc_i ? (SlotsPerCluster'(1'b1) << free_slot_o) : '0;
    w_rel_mask   = w_rel_legal ? (SlotsPerCluster'(1'b1) << release_slot_i) : '0;
  end

  // Bitmap register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_free <= {SlotsPerCluster{1'b1}};
    end else begin
      r_free <= (r_free & ~w_alloc_mask) | w_rel_mask;
    end
  end

endmodule

// File: rtl/cluster_task_sched.sv
// -----------------------------------------------------------------------------
// cluster_task_sched
// Assigns each incoming task a free buffer slot in one cluster (round-robin
// over clusters with a free slot, lowest free slot inside the cluster) and
// emits the slot's absolute L1 address through a one-entry output register.
// Slots return to the pool on done_valid_i.
//
// Ports
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   cl_start_addr_i                : per-cluster slot-region base, cluster c
//                                    at [c*AddrWidth +: AddrWidth]
//   task_valid_i/task_ready_o/task_id_i : task request handshake and tag
//   disp_valid_o/disp_ready_i      : dispatch handshake
//   disp_cluster_o/disp_slot_o/disp_addr_o/disp_id_o : dispatched entry
//   done_valid_i/done_cluster_i/done_slot_i : slot release
//   err_o                          : sticky double-free / out-of-range release
//   perf_disp_o, perf_stall_o      : dispatch and stall counters
//
// Build option: define CLUSTER_TASK_SCHED_PERF_EN to instantiate the perf
// counters; otherwise both perf outputs are constant 0.
// -----------------------------------------------------------------------------
module cluster_task_sched
  import cluster_task_sched_pkg::*;
#(
  parameter  int unsigned NumClusters     = 32'd4,
  parameter  int unsigned AddrWidth       = 32'd32,
  parameter  int unsigned SlotsPerCluster = 32'd8,
  parameter  int unsigned SlotBytes       = 32'h400,
  parameter  int unsigned TaskIdWidth     = 32'd8,
  localparam int unsigned ClW             = idx_width(NumClusters),
  localparam int unsigned SlotW           = $clog2(SlotsPerCluster)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumClusters*AddrWidth-1:0] cl_start_addr_i,
  input  logic                             task_valid_i,
  output logic                             task_ready_o,
  input  logic [TaskIdWidth-1:0]           task_id_i,
  output logic                             disp_valid_o,
  input  logic                             disp_ready_i,
  output logic [ClW-1:0]                   disp_cluster_o,
  output logic [SlotW-1:0]                 disp_slot_o,
  output logic [AddrWidth-1:0]             disp_addr_o,
  output logic [TaskIdWidth-1:0]           disp_id_o,
  input  logic                             done_valid_i,
  input  logic [ClW-1:0]                   done_cluster_i,
  input  logic [SlotW-1:0]                 done_slot_i,
  output logic                             err_o,
  output logic [31:0]                      perf_disp_o,
  output logic [31:0]                      perf_stall_o
);

  out_state_e               r_state;
  out_state_e               w_state_nxt;
  logic [ClW-1:0]           r_rr;
  logic [ClW-1:0]           r_cl;
  logic [SlotW-1:0]         r_slot;
  logic [AddrWidth-1:0]     r_addr;
  logic [TaskIdWidth-1:0]   r_id;
  logic                     r_err;

  logic [NumClusters-1:0]   w_any_free;
  logic [NumClusters-1:0]   w_alloc;
  logic [NumClusters-1:0]   w_release;
  logic [NumClusters-1:0]   w_dbl_free;
  logic [SlotW-1:0]         w_free_slot [NumClusters];

  logic                     w_pick_found;
  logic [ClW-1:0]           w_pick;
  logic [ClW-1:0]           w_cand;
  logic                     w_hit;
  logic                     w_hs;
  logic                     w_accept;
  logic                     w_done_oor;
  logic [SlotW-1:0]         w_sel_slot;
  logic [AddrWidth-1:0]     w_base;
  logic [AddrWidth-1:0]     w_addr;
  logic [ClW-1:0]           w_rr_nxt;

  // Per-cluster slot bitmaps.
  for (genvar g = 0; g < NumClusters; g++) begin : g_cl
    cluster_slot_alloc #(
      .SlotsPerCluster (SlotsPerCluster)
    ) u_alloc (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .alloc_i        (w_alloc[g]),
      .release_i      (w_release[g]),
      .release_slot_i (done_slot_i),
      .any_free_o     (w_any_free[g]),
      .free_slot_o    (w_free_slot[g]),
      .err_o          (w_dbl_free[g])
    );
  end

  // Round-robin pick: first cluster with a free slot at or after r_rr.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_cand       = '0;
    w_hit        = 1'b0;
    for (int i = 0; i < int'(NumClusters); i++) begin
      w_cand       = ClW'((32'(r_rr) + unsigned'(i)) % NumClusters);
      w_hit        = ~w_pick_found & w_any_free[w_cand];
      w_pick       = w_hit ? w_cand : w_pick;
      w_pick_found = w_pick_found | w_hit;
    end
  end

  // Handshakes, slot selection, address and release routing.
  always_comb begin
    w_hs         = (r_state == OUT_FULL) & disp_ready_i;
    task_ready_o = ((r_state == OUT_EMPTY) | w_hs) & w_pick_found;
    w_accept     = task_valid_i & task_ready_o;
    w_alloc      = w_accept ? (NumClusters'(1'b1) << w_pick) : '0;
    w_sel_slot   = w_free_slot[w_pick];
    w_base       = cl_start_addr_i[32'(w_pick) * AddrWidth +: AddrWidth];
    w_addr       = AddrWidth'(slot_addr(64'(w_base), 32'(w_sel_slot), 32'(SlotBytes)));
    w_rr_nxt     = (32'(w_pick) == (NumClusters - 32'd1)) ? '0 : (w_pick + ClW'(1'b1));
    w_done_oor   = done_valid_i & (32'(done_cluster_i) >= NumClusters);
    for (int i = 0; i < int'(NumClusters); i++) begin
      w_release[i] = done_valid_i & (done_cluster_i == ClW'(i));
    end
  end

  // Output register occupancy: a new accept keeps it FULL even while the
  // current entry leaves, which gives one task per cycle under full flow.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: w_state_nxt = w_accept ? OUT_FULL : OUT_EMPTY;
      OUT_FULL:  w_state_nxt = (w_accept | ~disp_ready_i) ? OUT_FULL : OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output payload and round-robin pointer, both updated only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cl   <= '0;
      r_slot <= '0;
      r_addr <= '0;
      r_id   <= '0;
      r_rr   <= '0;
    end else if (w_accept) begin
      r_cl   <= w_pick;
      r_slot <= w_sel_slot;
      r_addr <= w_addr;
      r_id   <= task_id_i;
      r_rr   <= w_rr_nxt;
    end
  end

  // Sticky release error, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_done_oor | (|w_dbl_free);
    end
  end

  assign disp_valid_o   = (r_state == OUT_FULL);
  assign disp_cluster_o = r_cl;
  assign disp_slot_o    = r_slot;
  assign disp_addr_o    = r_addr;
  assign disp_id_o      = r_id;
  assign err_o          = r_err;

`ifdef CLUSTER_TASK_SCHED_PERF_EN
  logic [31:0] r_perf_disp;
  logic [31:0] r_perf_stall;

  // Dispatch and stall counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_disp  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_hs) begin
        r_perf_disp <= r_perf_disp + 32'd1;
      end
      if (task_valid_i & ~task_ready_o) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_disp_o  = r_perf_disp;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_disp_o  = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_cluster_task_sched.sv
module tb_cluster_task_sched;

  localparam int unsigned NC  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned SPC = 4;
  localparam int unsigned IDW = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NC*AW-1:0]  cl_start_addr_i;
  logic              task_valid_i = 1'b0;
  logic              task_ready_o;
  logic [IDW-1:0]    task_id_i = '0;
  logic              disp_valid_o;
  logic              disp_ready_i = 1'b1;
  logic [1:0]        disp_cluster_o;
  logic [1:0]        disp_slot_o;
  logic [AW-1:0]     disp_addr_o;
  logic [IDW-1:0]    disp_id_o;
  logic              done_valid_i = 1'b0;
  logic [1:0]        done_cluster_i = '0;
  logic [1:0]        done_slot_i = '0;
  logic              err_o;
  logic [31:0]       perf_disp_o;
  logic [31:0]       perf_stall_o;

  cluster_task_sched #(
    .NumClusters     (NC),
    .AddrWidth       (AW),
    .SlotsPerCluster (SPC),
    .SlotBytes       (32'h400),
    .TaskIdWidth     (IDW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cl_start_addr_i (cl_start_addr_i),
    .task_valid_i    (task_valid_i),
    .task_ready_o    (task_ready_o),
    .task_id_i       (task_id_i),
    .disp_valid_o    (disp_valid_o),
    .disp_ready_i    (disp_ready_i),
    .disp_cluster_o  (disp_cluster_o),
    .disp_slot_o     (disp_slot_o),
    .disp_addr_o     (disp_addr_o),
    .disp_id_o       (disp_id_o),
    .done_valid_i    (done_valid_i),
    .done_cluster_i  (done_cluster_i),
    .done_slot_i     (done_slot_i),
    .err_o           (err_o),
    .perf_disp_o     (perf_disp_o),
    .perf_stall_o    (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard and reference model ----------------
  typedef struct {
    int          cl;
    int          slot;
    logic [31:0] addr;
    logic [7:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit   busy[NC][SPC];   // 1 = slot handed out
  int   rr;
  bit   m_full;
  bit   m_err;
  int   m_disp;
  int   m_stall;
  bit   last_acc;

  function automatic logic [31:0] base_of(input int c);
    return 32'h1000_0000 + 32'(c) * 32'h0040_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle with the inputs currently driven: compare the DUT against
  // the model at the falling edge, then advance the model to the next cycle.
  task automatic step();
    bit   found;
    bit   exp_ready;
    bit   rel_ok;
    int   pc;
    int   ps;
    int   dc;
    int   ds;
    found = 1'b0;
    pc = 0;
    ps = 0;
    @(negedge clk_i);
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (rr + k) % NC;
      if (!found) begin
        for (int s = 0; s < SPC; s++) begin
          if (!found && !busy[c][s]) begin
            found = 1'b1;
            pc = c;
            ps = s;
          end
        end
      end
    end
    exp_ready = found && (!m_full || disp_ready_i);
    chk("task_ready", task_ready_o, exp_ready);
    chk("disp_valid", disp_valid_o, m_full);
    chk("err", err_o, m_err);
`ifdef CLUSTER_TASK_SCHED_PERF_EN
    chk("perf_disp", perf_disp_o, m_disp);
    chk("perf_stall", perf_stall_o, m_stall);
`else
    chk("perf_disp_off", perf_disp_o, 0);
    chk("perf_stall_off", perf_stall_o, 0);
`endif
    if (task_valid_i && !exp_ready) m_stall++;
    if (m_full && disp_ready_i) m_disp++;
    dc = int'(done_cluster_i);
    ds = int'(done_slot_i);
    rel_ok = 1'b0;
    if (done_valid_i) begin
      rel_ok = busy[dc][ds];
      if (!rel_ok) m_err = 1'b1;
    end
    last_acc = task_valid_i && exp_ready;
    if (last_acc) begin
      exp_t e;
      busy[pc][ps] = 1'b1;
      rr = (pc + 1) % NC;
      e.cl = pc;
      e.slot = ps;
      e.addr = base_of(pc) + 32'(ps) * 32'h400;
      e.id = task_id_i;
      exp_q.push_back(e);
      m_full = 1'b1;
    end else if (m_full && disp_ready_i) begin
      m_full = 1'b0;
    end
    if (rel_ok) busy[dc][ds] = 1'b0;
    @(posedge clk_i);
    #1;
    done_valid_i = 1'b0;
  endtask

  // Hold a task until accepted; returns the number of cycles it took.
  task automatic issue(input logic [7:0] id, output int n);
    n = 0;
    task_valid_i = 1'b1;
    task_id_i = id;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    chk("issue_accept_bound", last_acc, 1);
    task_valid_i = 1'b0;
  endtask

  task automatic release_slot(input int c, input int s);
    done_valid_i = 1'b1;
    done_cluster_i = 2'(c);
    done_slot_i = 2'(s);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    task_valid_i = 1'b0;
    disp_ready_i = 1'b1;
    done_valid_i = 1'b0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < SPC; s++) busy[c][s] = 1'b0;
    rr = 0;
    m_full = 1'b0;
    m_err = 1'b0;
    m_disp = 0;
    m_stall = 0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_disp_valid", disp_valid_o, 0);
    chk("rst_disp_cluster", disp_cluster_o, 0);
    chk("rst_disp_slot", disp_slot_o, 0);
    chk("rst_disp_addr", disp_addr_o, 0);
    chk("rst_disp_id", disp_id_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_perf_disp", perf_disp_o, 0);
    chk("rst_perf_stall", perf_stall_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- monitor: pops on each dispatch handshake ----------------
  bit          hold = 1'b0;
  logic [1:0]  sv_cl;
  logic [1:0]  sv_slot;
  logic [31:0] sv_addr;
  logic [7:0]  sv_id;
  exp_t        got;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stable_cluster", disp_cluster_o, sv_cl);
        chk("stable_slot", disp_slot_o, sv_slot);
        chk("stable_addr", disp_addr_o, sv_addr);
        chk("stable_id", disp_id_o, sv_id);
      end
      if (disp_valid_o && disp_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dispatch", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("sb_cluster", disp_cluster_o, got.cl);
          chk("sb_slot", disp_slot_o, got.slot);
          chk("sb_addr", disp_addr_o, got.addr);
          chk("sb_id", disp_id_o, got.id);
        end
      end
      hold = disp_valid_o && !disp_ready_i;
      sv_cl = disp_cluster_o;
      sv_slot = disp_slot_o;
      sv_addr = disp_addr_o;
      sv_id = disp_id_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < NC; i++) cl_start_addr_i[i*AW +: AW] = base_of(i);

    // 1. reset round-robin
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      issue(8'(k), n);
      chk("s1_one_cycle", n, 1);
      chk("s1_cluster", disp_cluster_o, k - 1);
      chk("s1_slot", disp_slot_o, 0);
      chk("s1_addr", disp_addr_o, 32'h1000_0000 + 32'(k - 1) * 32'h0040_0000);
    end

    // 2. exhaustion, then a release frees the waiting 17th task
    for (int k = 5; k <= 16; k++) issue(8'(k), n);
    task_valid_i = 1'b1;
    task_id_i = 8'd17;
    repeat (4) begin
      step();
      chk("s2_blocked", last_acc, 0);
    end
    release_slot(2, 1);
    step();
    chk("s2_blocked_release_cycle", last_acc, 0);
    step();
    chk("s2_accept", last_acc, 1);
    chk("s2_cluster", disp_cluster_o, 2);
    chk("s2_slot", disp_slot_o, 1);
    chk("s2_addr", disp_addr_o, 32'h1080_0400);
    task_valid_i = 1'b0;
    repeat (2) step();

    // 3. back-pressure
    do_reset();
    disp_ready_i = 1'b0;
    issue(8'hA1, n);
    task_valid_i = 1'b1;
    task_id_i = 8'hA2;
    repeat (5) begin
      step();
      chk("s3_wait", last_acc, 0);
    end
    disp_ready_i = 1'b1;
    step();
    chk("s3_accept_on_ready", last_acc, 1);
    task_valid_i = 1'b0;
    repeat (2) step();

    // 4. double free: sticky error, bitmap unchanged
    do_reset();
    release_slot(1, 3);
    step();
    chk("s4_err_set", err_o, 1);
    for (int k = 0; k < 8; k++) issue(8'(8'h40 + k), n);
    repeat (2) step();
    chk("s4_err_sticky", err_o, 1);

    // 5. same-cycle release and allocation
    do_reset();
    for (int k = 0; k < 16; k++) issue(8'(8'h50 + k), n);
    release_slot(3, 2);
    step();
    release_slot(0, 0);
    issue(8'h60, n);
    chk("s5_first_cluster", disp_cluster_o, 3);
    chk("s5_first_slot", disp_slot_o, 2);
    issue(8'h61, n);
    chk("s5_next_cluster", disp_cluster_o, 0);
    chk("s5_next_slot", disp_slot_o, 0);
    chk("s5_next_addr", disp_addr_o, 32'h1000_0000);
    repeat (2) step();

    // 6. perf counters: 10 dispatches, 3 stall cycles
    do_reset();
    issue(8'd1, n);
    disp_ready_i = 1'b0;
    task_valid_i = 1'b1;
    task_id_i = 8'd2;
    repeat (3) step();
    disp_ready_i = 1'b1;
    step();
    task_valid_i = 1'b0;
    for (int k = 3; k <= 10; k++) issue(8'(k), n);
    repeat (2) step();
`ifdef CLUSTER_TASK_SCHED_PERF_EN
    chk("s6_perf_disp", perf_disp_o, 10);
    chk("s6_perf_stall", perf_stall_o, 3);
`else
    chk("s6_perf_disp_off", perf_disp_o, 0);
    chk("s6_perf_stall_off", perf_stall_o, 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!task_valid_i && $urandom_range(0, 3) != 0) begin
        task_valid_i = 1'b1;
        task_id_i = 8'($urandom);
      end
      disp_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int c;
        int s;
        c = int'($urandom_range(0, NC - 1));
        s = int'($urandom_range(0, SPC - 1));
        if (busy[c][s]) release_slot(c, s);
      end
      step();
      if (last_acc) task_valid_i = 1'b0;
    end
    task_valid_i = 1'b0;
    disp_ready_i = 1'b1;
    repeat (3) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
